// File: rtl/bp_pkg.sv
// Shared types and helpers for the BTB-based branch predictor: entry layout,
// counter encodings and PC index/tag extraction.
package bp_pkg;

    // Fields are sized for the widest supported configuration. Each instance
    // uses only the low XLEN / CTR_W bits, and the unused upper bits stay constant.
    localparam int XLEN_MAX  = 64;
    localparam int CTR_W_MAX = 8;

    typedef struct packed {
        logic                 valid;
        logic [XLEN_MAX-1:0]  tag;
        logic [XLEN_MAX-1:0]  target;
        logic [CTR_W_MAX-1:0] ctr;
    } btb_entry_t;

    // Weakly-not-taken: MSB clear, all lower bits set (0 for a 1-bit counter).
    function automatic logic [CTR_W_MAX-1:0] ctr_wnt(input int ctr_w);
        return CTR_W_MAX'((1 << (ctr_w - 1)) - 1);
    endfunction

    // Weakly-taken: MSB set, all lower bits clear.
    function automatic logic [CTR_W_MAX-1:0] ctr_wt(input int ctr_w);
        return CTR_W_MAX'(1 << (ctr_w - 1));
    endfunction

    function automatic logic [31:0] bp_index(input logic [XLEN_MAX-1:0] pc, input int idx_w);
        return 32'((pc >> 2) & ((XLEN_MAX'(1) << idx_w) - XLEN_MAX'(1)));
    endfunction

    function automatic logic [XLEN_MAX-1:0] bp_tag(input logic [XLEN_MAX-1:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Combinational saturating up/down counter step used on the BTB training path.
module sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] ctr_i,
    input  logic         inc_i,
    output logic [W-1:0] ctr_o
);

    always_comb begin
        // NOTE: default assignment first, so every path drives ctr_o and no latch is inferred.
        ctr_o = ctr_i;
        if (inc_i && (ctr_i != {W{1'b1}})) begin
            ctr_o = ctr_i + W'(1);
        end else if (!inc_i && (ctr_i != '0)) begin
            ctr_o = ctr_i - W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating counters. IF looks it up combinationally,
// and ID trains it and reports mispredicts and the redirect PC.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [XLEN-1:0]  lk_pc_i,
    output logic             pred_taken_o,
    output logic [XLEN-1:0]  pred_target_o,
    input  logic             upd_valid_i,
    input  logic [XLEN-1:0]  upd_pc_i,
    input  logic             upd_taken_i,
    input  logic [XLEN-1:0]  upd_target_i,
    input  logic             upd_pred_taken_i,
    input  logic [XLEN-1:0]  upd_pred_target_i,
    output logic             mispredict_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W_MAX-1:0] CTR_RESET = ctr_wnt(CTR_W);
    localparam logic [CTR_W_MAX-1:0] CTR_ALLOC = ctr_wt(CTR_W);

    btb_entry_t          btb_q [ENTRIES];
    logic [CNT_W-1:0]    branch_cnt_q;
    logic [CNT_W-1:0]    mispred_cnt_q;

    logic [IDX_W-1:0]    lk_idx;
    logic [IDX_W-1:0]    upd_idx;
    logic [XLEN_MAX-1:0] lk_tag;
    logic [XLEN_MAX-1:0] upd_tag;
    logic                lk_hit;
    logic                upd_hit;
    logic [CTR_W-1:0]    upd_ctr_next;

    assign lk_idx  = IDX_W'(bp_index(XLEN_MAX'(lk_pc_i), IDX_W));
    assign lk_tag  = bp_tag(XLEN_MAX'(lk_pc_i), IDX_W);
    assign upd_idx = IDX_W'(bp_index(XLEN_MAX'(upd_pc_i), IDX_W));
    assign upd_tag = bp_tag(XLEN_MAX'(upd_pc_i), IDX_W);

    assign lk_hit  = btb_q[lk_idx].valid && (btb_q[lk_idx].tag == lk_tag);
    assign upd_hit = btb_q[upd_idx].valid && (btb_q[upd_idx].tag == upd_tag);

    assign pred_taken_o  = lk_hit && btb_q[lk_idx].ctr[CTR_W-1];
    assign pred_target_o = pred_taken_o ? btb_q[lk_idx].target[XLEN-1:0] : lk_pc_i + XLEN'(4);

    assign mispredict_o  = upd_valid_i &&
                           ((upd_taken_i != upd_pred_taken_i) ||
                            (upd_taken_i && (upd_pred_target_i != upd_target_i)));
    assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + XLEN'(4);

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

    sat_counter #(.W(CTR_W)) u_upd_ctr (
        .ctr_i (btb_q[upd_idx].ctr[CTR_W-1:0]),
        .inc_i (upd_taken_i),
        .ctr_o (upd_ctr_next)
    );

    // A same-cycle lookup sees the pre-update entry, because there is no bypass.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
        if (rst_i) begin
            // NOTE: the table is a resettable register array. A memory with a reset cannot map to SRAM.
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (upd_valid_i) begin
            branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            if (mispredict_o) begin
                mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
            end
            if (upd_hit) begin
                btb_q[upd_idx].ctr <= CTR_W_MAX'(upd_ctr_next);
                if (upd_taken_i) begin
                    btb_q[upd_idx].target <= XLEN_MAX'(upd_target_i);
                end
            end else if (upd_taken_i) begin
                btb_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag,
                                    target: XLEN_MAX'(upd_target_i), ctr: CTR_ALLOC};
            end
        end
    end

endmodule
